// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands one requester's byte at a time to a UART transmitter,
// tracking the transmitter's busy/done handshake and a bounded wait for busy.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned BUSY_TIMEOUT = 1023
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              ack,
    output logic [NUM_REQ-1:0]              done,
    output logic                            tx_en,
    output logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            tx_busy,
    input  logic                            tx_done,
    output logic [$clog2(NUM_REQ)-1:0]      owner,
    output logic                            active,
    output logic                            timeout_err
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWaitBusy,
        StWaitDone
    } state_e;

    state_e                  state_q;
    logic [IdxW-1:0]         rr_ptr_q;
    logic [IdxW-1:0]         owner_q;
    logic [CntW-1:0]         cnt_q;
    logic                    tx_done_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [NUM_REQ-1:0]      ack_q;
    logic [NUM_REQ-1:0]      done_q;
    logic                    tx_en_q;
    logic                    timeout_q;

    logic                    win_valid;
    logic [IdxW-1:0]         win_idx;
    logic [DATA_WIDTH-1:0]   win_data;
    logic                    done_rise;

    function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] base,
                                                 input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        return IdxW'(sum % NUM_REQ);
    endfunction

    // Scan from the largest offset down so the requester nearest rr_ptr wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[wrap_idx(rr_ptr_q, i)]) begin
                win_valid = 1'b1;
                win_idx   = wrap_idx(rr_ptr_q, i);
            end
        end
    end

    assign win_data  = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
    assign done_rise = tx_done & ~tx_done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            tx_done_q <= 1'b0;
            data_q    <= '0;
            ack_q     <= '0;
            done_q    <= '0;
            tx_en_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            tx_done_q <= tx_done;
            ack_q     <= '0;
            done_q    <= '0;
            tx_en_q   <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (win_valid) begin
                        data_q         <= win_data;
                        owner_q        <= win_idx;
                        ack_q[win_idx] <= 1'b1;
                        tx_en_q        <= 1'b1;
                        state_q        <= StStart;
                    end
                end
                StStart: begin
                    cnt_q   <= '0;
                    state_q <= StWaitBusy;
                end
                StWaitBusy: begin
                    // A completion edge wins over busy so a fast transmitter is not lost.
                    if (done_rise) begin
                        done_q[owner_q] <= 1'b1;
                        rr_ptr_q        <= wrap_idx(owner_q, 1);
                        state_q         <= StIdle;
                    end else if (tx_busy) begin
                        state_q <= StWaitDone;
                    end else if (cnt_q == CntLast) begin
                        timeout_q <= 1'b1;
                        rr_ptr_q  <= wrap_idx(owner_q, 1);
                        state_q   <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (done_rise) begin
                        done_q[owner_q] <= 1'b1;
                        rr_ptr_q        <= wrap_idx(owner_q, 1);
                        state_q         <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ack         = ack_q;
    assign done        = done_q;
    assign tx_en       = tx_en_q;
    assign data_in     = data_q;
    assign owner       = owner_q;
    assign active      = (state_q != StIdle);
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single byte, contention, fairness, coincident
// busy/done, busy timeout and reset in mid-transfer.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic        tx_en;
    logic [7:0]  data_in;
    logic        tx_busy;
    logic        tx_done;
    logic [1:0]  owner;
    logic        active;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .DATA_WIDTH   (8),
        .BUSY_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .done        (done),
        .tx_en       (tx_en),
        .data_in     (data_in),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .owner       (owner),
        .active      (active),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ack"}, 32'(ack), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_txen"}, 32'(tx_en), 32'h0);
        chk({tag, "_data"}, 32'(data_in), 32'h0);
        chk({tag, "_owner"}, 32'(owner), 32'h0);
        chk({tag, "_active"}, 32'(active), 32'h0);
        chk({tag, "_tmo"}, 32'(timeout_err), 32'h0);
    endtask

    // Advance one edge from IDLE and expect a grant to the given requester.
    task automatic grant_check(input string tag, input int own, input logic [7:0] dat);
        step();
        chk({tag, "_ack"}, 32'(ack), 32'(4'b0001 << own));
        chk({tag, "_txen"}, 32'(tx_en), 32'h1);
        chk({tag, "_data"}, 32'(data_in), 32'(dat));
        chk({tag, "_owner"}, 32'(owner), 32'(own));
    endtask

    // From the START cycle: transmitter goes busy, then completes.
    task automatic finish_xfer(input string tag, input int own, input logic [7:0] dat);
        step();
        chk({tag, "_txen_low"}, 32'(tx_en), 32'h0);
        tx_busy = 1'b1;
        step();
        step();
        chk({tag, "_hold"}, 32'(data_in), 32'(dat));
        tx_done = 1'b1;
        tx_busy = 1'b0;
        step();
        chk({tag, "_done"}, 32'(done), 32'(4'b0001 << own));
        chk({tag, "_ack_zero"}, 32'(ack), 32'h0);
        chk({tag, "_idle"}, 32'(active), 32'h0);
        tx_done = 1'b0;
    endtask

    initial begin
        bit tmo_early;
        reset    = 1'b1;
        req      = 4'b0000;
        req_data = 32'h0;
        tx_busy  = 1'b0;
        tx_done  = 1'b0;
        step();
        step();
        chk_idle_outputs("rst");
        reset = 1'b0;
        step();

        // Single request
        req      = 4'b0001;
        req_data = 32'h0000_00AA;
        grant_check("single", 0, 8'hAA);
        chk("single_active", 32'(active), 32'h1);
        req = 4'b0000;
        finish_xfer("single", 0, 8'hAA);
        step();
        step();
        chk("idle_hold_data", 32'(data_in), 32'hAA);
        chk("idle_stays", 32'(active), 32'h0);

        // Contention from rr_ptr 0
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        req      = 4'b1111;
        req_data = 32'h4332_2110;
        grant_check("cont0", 0, 8'h10);
        finish_xfer("cont0", 0, 8'h10);
        grant_check("cont1", 1, 8'h21);
        finish_xfer("cont1", 1, 8'h21);
        grant_check("cont2", 2, 8'h32);
        finish_xfer("cont2", 2, 8'h32);
        grant_check("cont3", 3, 8'h43);
        finish_xfer("cont3", 3, 8'h43);
        grant_check("cont4", 0, 8'h10);
        finish_xfer("cont4", 0, 8'h10);

        // Fairness: req[0] held, req[2] joins mid-transfer
        req = 4'b0001;
        grant_check("fair0", 0, 8'h10);
        req = 4'b0101;
        finish_xfer("fair0", 0, 8'h10);
        grant_check("fair2", 2, 8'h32);
        finish_xfer("fair2", 2, 8'h32);
        grant_check("fair0b", 0, 8'h10);
        req = 4'b0000;
        finish_xfer("fair0b", 0, 8'h10);

        // Coincident busy and done rise in WAIT_BUSY
        req = 4'b0010;
        grant_check("coin", 1, 8'h21);
        req = 4'b0000;
        step();
        tx_busy = 1'b1;
        tx_done = 1'b1;
        step();
        chk("coin_done", 32'(done), 32'b0010);
        chk("coin_idle", 32'(active), 32'h0);
        tx_busy = 1'b0;
        tx_done = 1'b0;
        step();
        chk("coin_single", 32'(done), 32'h0);

        // Timeout with tx_busy held low
        req = 4'b0100;
        grant_check("tmo", 2, 8'h32);
        req = 4'b0000;
        step();
        tmo_early = 1'b0;
        for (int i = 1; i < 16; i++) begin
            step();
            if (timeout_err !== 1'b0 || active !== 1'b1) tmo_early = 1'b1;
        end
        chk("tmo_not_early", 32'(tmo_early), 32'h0);
        step();
        chk("tmo_pulse", 32'(timeout_err), 32'h1);
        chk("tmo_no_done", 32'(done), 32'h0);
        chk("tmo_idle", 32'(active), 32'h0);
        step();
        chk("tmo_one_cycle", 32'(timeout_err), 32'h0);

        // rr_ptr advanced to 3: requester 0 beats requester 2
        req = 4'b0101;
        grant_check("tmo_ptr", 0, 8'h10);
        req = 4'b0000;
        step();
        tx_busy = 1'b1;
        step();
        step();

        // Reset in WAIT_DONE
        reset = 1'b1;
        #1;
        chk_idle_outputs("mid_rst");
        step();
        reset   = 1'b0;
        tx_busy = 1'b0;
        tx_done = 1'b1;
        step();
        chk("mid_rst_no_done", 32'(done), 32'h0);
        step();
        chk("mid_rst_no_done2", 32'(done), 32'h0);
        tx_done = 1'b0;
        step();
        req = 4'b1010;
        grant_check("post_rst", 1, 8'h21);
        req = 4'b0000;
        finish_xfer("post_rst", 1, 8'h21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, byte width handed to the transmitter.
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 1023, maximum cycles to wait for tx_busy after a start.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester "byte pending" level.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  packed bytes, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port ack  output  NUM_REQ  one-cycle pulse: requester's byte latched.
REQ-009 SHALL have port done  output  NUM_REQ  one-cycle pulse: requester's byte fully transmitted.
REQ-010 SHALL have port tx_en  output  1  one-cycle start pulse to transmitter.
REQ-011 SHALL have port data_in  output  DATA_WIDTH  byte presented to transmitter.
REQ-012 SHALL have port tx_busy  input  1  transmitter busy level.
REQ-013 SHALL have port tx_done  input  1  transmitter completion flag; completion = its 0->1 transition.
REQ-014 SHALL have port owner  output  clog2(NUM_REQ)  index of requester currently granted.
REQ-015 SHALL have port active  output  1  high in every state except IDLE.
REQ-016 SHALL have port timeout_err  output  1  one-cycle pulse when BUSY_TIMEOUT expires.

Function
REQ-017 SHALL implement FSM states IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-018 IDLE with any req bit high SHALL, in that cycle, select winner by round-robin from pointer rr_ptr upward with wrap to 0, and on the next edge latch req_data of winner into data_in, set owner, pulse ack[winner], enter START.
REQ-019 IDLE with req all zero SHALL remain in IDLE; data_in holds last value.
REQ-020 START SHALL assert tx_en for exactly one cycle with data_in stable, then enter WAIT_BUSY.
REQ-021 data_in SHALL stay constant from START until return to IDLE.
REQ-022 WAIT_BUSY SHALL enter WAIT_DONE on first cycle tx_busy=1; if tx_busy and a tx_done rising edge coincide, the edge SHALL be honoured as completion (see REQ-024).
REQ-023 WAIT_BUSY SHALL count cycles from 0; when count reaches BUSY_TIMEOUT with tx_busy still 0, pulse timeout_err, do not pulse done, advance rr_ptr to owner+1 (mod NUM_REQ), return to IDLE.
REQ-024 WAIT_DONE (or WAIT_BUSY) on tx_done 0->1 SHALL pulse done[owner] one cycle, set rr_ptr=owner+1 mod NUM_REQ, return to IDLE.
REQ-025 tx_done edge detect SHALL use a registered previous value of tx_done, updated every cycle in every state.
REQ-026 Earliest next grant SHALL be the cycle after return to IDLE (no back-to-back grant in the done cycle); byte-to-byte overhead therefore 3 cycles plus transmitter latency.
REQ-027 Requesters SHALL hold req and req_data until ack; req changes while not in IDLE SHALL be ignored.
REQ-028 A requester still holding req after its done SHALL lose priority to any other pending requester (fairness via rr_ptr).
REQ-029 At most one ack bit and one done bit SHALL be high in any cycle; ack and done SHALL never be high in the same cycle.

Reset
REQ-030 reset high SHALL immediately force: state IDLE, rr_ptr 0, owner 0, data_in 0, tx_en 0, ack 0, done 0, timeout_err 0, active 0, timeout counter 0, tx_done history 0.
REQ-031 reset asserted mid-transfer SHALL abandon the byte with no done pulse; after release first grant follows REQ-018 from rr_ptr 0.

Verification
REQ-032 Single request: req=0001, req_data[7:0]=8'hAA, model transmitter busy 2 cycles after tx_en -> ack[0] next edge, tx_en one cycle with data_in=8'hAA, done[0] on tx_done rise, active low after.
REQ-033 Contention: req=1111, bytes 8'h10,8'h21,8'h32,8'h43 held -> tx_en sequence data_in 10,21,32,43 with owner 0,1,2,3; fifth grant back to owner 0.
REQ-034 Fairness: req[0] held permanently, req[2] asserts during requester 0's transfer -> next grant owner 2, then owner 0.
REQ-035 Timeout: BUSY_TIMEOUT=16, tx_busy tied 0 -> timeout_err pulse 16 cycles after entering WAIT_BUSY, no done, state IDLE, rr_ptr advanced.
REQ-036 Reset mid-op: assert reset in WAIT_DONE -> all outputs at REQ-030 values same cycle; later tx_done rise produces no done pulse.
REQ-037 Coincident: tx_busy rise and tx_done rise same cycle in WAIT_BUSY -> single done[owner] pulse, return to IDLE.
